apb_master_arb: RTL
===================

Name: apb_master_arb

Overview:
- Round-robin arbiter plus APB master sequencer for the PD0 APB fabric.
- Shares the single APB master port, which feeds the PD0 APB bus, between NREQ internal requesters (e.g. CPU bridge, DMA, debug).
- Each requester uses a simple valid/ready request channel and a one-cycle response pulse.
- The block generates compliant SETUP/ACCESS phases and returns PRDATA/PSLVERR to the granted requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock; one clock domain only.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request pending.
- req_write  in  NREQ  per-requester write(1)/read(0).
- req_addr  in  NREQ*32  packed addresses; requester i in bits [32i+31:32i].
- req_wdata  in  NREQ*32  packed write data; same packing.
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  NREQ  one-hot completion pulse.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  slave error, valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- All outputs are registered.
- Reset values:
  - PSEL, PENABLE, PWRITE: 0.
  - PADDR, PWDATA: 0.
  - req_ready, rsp_valid: 0.
  - rsp_rdata: 0; rsp_err: 0.
  - state: IDLE; rr_ptr: 0.
- Request handshake:
  - A requester holds req_valid and its payload stable until it sees req_ready.
  - Deasserting req_valid before grant is legal and has no effect.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching upward from rr_ptr, wrapping at NREQ.
  - Register PADDR, PWRITE, PWDATA from requester g; set PSEL=1, PENABLE=0, req_ready[g]=1; go to SETUP.
  - If no req_valid is set, outputs hold.
- SETUP:
  - req_ready returns to 0 (exactly one-cycle pulse).
  - Set PENABLE=1; go to ACCESS.
- ACCESS:
  - While PREADY=0: hold all APB outputs.
  - When PREADY=1:
    - rsp_rdata=PRDATA, or 0 for writes.
    - rsp_err=PSLVERR.
    - rsp_valid[g]=1 for one cycle.
    - PSEL=0, PENABLE=0.
    - rr_ptr=(g+1) mod NREQ.
    - Go to IDLE.
- PADDR, PWRITE and PWDATA hold their last values after a transfer.
- Timing:
  - Minimum 3 cycles per transfer (IDLE, SETUP, ACCESS).
  - rsp_valid is asserted in the IDLE cycle that follows completion.
  - Arbitration in that same IDLE cycle already uses the updated rr_ptr.
- Responses have no backpressure; the requester must accept rsp_valid.
- Simultaneous events:
  - A new req_valid arriving during SETUP/ACCESS waits for IDLE.
  - A lone requester can win back-to-back grants.
- PRESET mid-transfer:
  - Immediate return to IDLE, PSEL=PENABLE=0.
  - No rsp_valid is issued; rr_ptr=0.
- req_valid bits at index ≥ NREQ do not exist; rr_ptr never reaches NREQ.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT_CYCLES, the transfer terminates: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, PSEL=PENABLE=0, rr_ptr advances, state returns to IDLE.
  - PREADY=1 in the same cycle the limit is reached wins: normal completion.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: ACCESS waits indefinitely; TIMEOUT_CYCLES is unused and no counter is built.

Decomposition:
- Package apb_pkg holds:
  - APB_ADDR_W=32, APB_DATA_W=32.
  - State encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2.
  - MAX_NREQ=8.
- Sub-module rr_arbiter: combinational round-robin grant.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - Reusable by other fabrics.

Test Plan:
- Single read, NREQ=2: req0 read 0x64000010, slave PREADY=1 first ACCESS cycle with PRDATA=0xCAFEF00D -> PSEL 2 cycles, PENABLE 1 cycle, req_ready[0] pulse in SETUP, rsp_valid[0]=1 with rsp_rdata=0xCAFEF00D, rsp_err=0.
- Round robin: req0 and req1 both held valid for 4 transfers -> grant order 0,1,0,1, each rsp_valid routed to the matching bit.
- Wait states and error: req1 write 0x68000004 data 0x00000005, PREADY low 3 cycles then high with PSLVERR=1 -> PWDATA stable 0x5 for 5 cycles, rsp_valid[1]=1, rsp_err=1, rsp_rdata=0.
- Reset mid-ACCESS: assert PRESET while PREADY=0 -> next cycle PSEL=PENABLE=0, no rsp_valid, rr_ptr=0, state IDLE.
- Withdrawn request: req0 valid 1 cycle during another transfer then dropped -> never granted, no req_ready[0].
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4: PREADY held 0 -> terminate after 4 wait cycles with rsp_err=1. Repeat with PREADY=1 on the 4th cycle -> rsp_err=PSLVERR.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants and types for the APB master arbiter slice.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;
   localparam int MAX_NREQ   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Width of an index able to address n requesters (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus bundle between the arbiter (master side) and the PD0 APB fabric.
interface apb_master_arb_if;
   import apb_pkg::*;

   logic                  PSEL;
   logic                  PENABLE;
   logic [APB_ADDR_W-1:0] PADDR;
   logic                  PWRITE;
   logic [APB_DATA_W-1:0] PWDATA;
   logic [APB_DATA_W-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_master_arb_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending request at or
// above ptr, wrapping at NREQ. Reusable by other fabrics.
module rr_arbiter
   import apb_pkg::*;
#(
   parameter  int NREQ  = 2,
   localparam int IDX_W = idx_width(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);

   logic             found;
   int               scan_i;
   logic [IDX_W-1:0] scan_idx;

   // Scan upward from ptr with wrap; the first set request wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      scan_i    = 0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_i = int'(ptr) + k;
         if (scan_i >= NREQ) begin
            scan_i = scan_i - NREQ;
         end
         scan_idx = IDX_W'(scan_i);
         if (!found && req[scan_idx]) begin
            found            = 1'b1;
            grant[scan_idx]  = 1'b1;
            grant_idx        = scan_idx;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin arbiter plus APB master sequencer for the PD0 APB fabric.
// Optional ACCESS-phase timeout is compiled in with the macro APB_TIMEOUT_EN.
module apb_master_arb
   import apb_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ*APB_ADDR_W-1:0] req_addr,
   input  logic [NREQ*APB_DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]            req_ready,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [APB_DATA_W-1:0]      rsp_rdata,
   output logic                       rsp_err,
   apb_master_arb_if.master           apb
);

   localparam int IDX_W = idx_width(NREQ);

   // Parameter sanity: an out-of-range configuration elaborates this
   // otherwise empty scope, which is easy to spot in the hierarchy.
   if (NREQ < 2 || NREQ > MAX_NREQ || TIMEOUT_CYCLES < 1) begin : g_param_out_of_range
   end

   apb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
   logic [NREQ-1:0]       req_ready_q, req_ready_d;
   logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
   logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

   logic [NREQ-1:0]       arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_any;
   logic                  sel_write;
   logic [APB_ADDR_W-1:0] sel_addr;
   logic [APB_DATA_W-1:0] sel_wdata;
   logic [IDX_W-1:0]      ptr_after_gnt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_req   (arb_any)
   );

   // Mux out the payload of whichever requester the arbiter is granting.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*APB_ADDR_W +: APB_ADDR_W];
            sel_wdata = req_wdata[i*APB_DATA_W +: APB_DATA_W];
         end
      end
   end

   assign ptr_after_gnt = (gnt_idx_q == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;

   // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequence.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_idx_d   = gnt_idx_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               gnt_idx_d   = arb_idx;
               paddr_d     = sel_addr;
               pwrite_d    = sel_write;
               pwdata_d    = sel_wdata;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               req_ready_d = arb_grant;
               state_d     = SETUP;
            end
         end

         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end

         ACCESS: begin
            if (apb.PREADY) begin
               rsp_rdata_d            = pwrite_q ? '0 : apb.PRDATA;
               rsp_err_d              = apb.PSLVERR;
               rsp_valid_d[gnt_idx_q] = 1'b1;
               psel_d                 = 1'b0;
               penable_d              = 1'b0;
               rr_ptr_d               = ptr_after_gnt;
               state_d                = IDLE;
            end
`ifdef APB_TIMEOUT_EN
            // The cycle in which the wait count would reach the limit ends
            // the transfer with an error instead of waiting further.
            else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_rdata_d            = '0;
               rsp_err_d              = 1'b1;
               rsp_valid_d[gnt_idx_q] = 1'b1;
               psel_d                 = 1'b0;
               penable_d              = 1'b0;
               rr_ptr_d               = ptr_after_gnt;
               state_d                = IDLE;
            end
            else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
`endif
         end

         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_idx_q   <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
`endif
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PWDATA  = pwdata_q;

endmodule
